// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache controller.
// The controller uses the slave modport; the pipeline/memory environment uses master.
interface dcache_ctrl_if;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_MemRd_i;
  logic        cpu_MemWr_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_MemWr_o;
  logic        mem_MemRd_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  cpu_addr_i, cpu_wdata_i, cpu_MemRd_i, cpu_MemWr_i, mem_rdata_i,
    output cpu_rdata_o, cpu_stall_o, mem_addr_o, mem_wdata_o, mem_MemWr_o, mem_MemRd_o
  );

  modport master (
    output cpu_addr_i, cpu_wdata_i, cpu_MemRd_i, cpu_MemWr_i, mem_rdata_i,
    input  cpu_rdata_o, cpu_stall_o, mem_addr_o, mem_wdata_o, mem_MemWr_o, mem_MemRd_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller, one word per line.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int IDX_W   = 2,
  parameter int MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               valid_r [LINES];
  logic               dirty_r [LINES];
  logic [TAG_W-1:0]   tag_r   [LINES];
  logic [31:0]        data_r  [LINES];

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               req_s;
  logic               hit_s;
  logic               victim_dirty_s;
  logic               last_s;
  logic               unused_addr_s;

  assign idx_s          = bus.cpu_addr_i[IDX_W+1:2];
  assign tag_s          = bus.cpu_addr_i[31:IDX_W+2];
  assign req_s          = bus.cpu_MemRd_i | bus.cpu_MemWr_i;
  assign hit_s          = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign victim_dirty_s = valid_r[idx_s] & dirty_r[idx_s];
  assign last_s         = (cnt_r == CNT_LAST);
  assign unused_addr_s  = ^bus.cpu_addr_i[1:0];

  // Output decode: stall must rise in the same cycle a miss is seen, so outputs follow state and request.
  always_comb begin
    bus.cpu_stall_o = 1'b0;
    bus.cpu_rdata_o = 32'd0;
    bus.mem_addr_o  = 32'd0;
    bus.mem_wdata_o = 32'd0;
    bus.mem_MemWr_o = 1'b0;
    bus.mem_MemRd_o = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst_i) begin
          bus.cpu_stall_o = 1'b0;
        end else if (req_s && !hit_s) begin
          bus.cpu_stall_o = 1'b1;
        end else if (bus.cpu_MemRd_i && !bus.cpu_MemWr_i && hit_s) begin
          // A store wins when both strobes are high, so only a pure load returns data.
          bus.cpu_rdata_o = data_r[idx_s];
        end else begin
          bus.cpu_stall_o = 1'b0;
        end
      end
      WB: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_MemWr_o = 1'b1;
        bus.mem_addr_o  = {tag_r[idx_s], idx_s, 2'b00};
        bus.mem_wdata_o = data_r[idx_s];
      end
      FILL: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_MemRd_o = 1'b1;
        bus.mem_addr_o  = {tag_s, idx_s, 2'b00};
      end
      default: begin
        bus.cpu_stall_o = 1'b0;
      end
    endcase
  end

  // Controller FSM plus tag/data array updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      for (int i = 0; i < LINES; i++) begin
        valid_r[i] <= 1'b0;
        dirty_r[i] <= 1'b0;
        tag_r[i]   <= '0;
        data_r[i]  <= 32'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (req_s && hit_s) begin
            if (bus.cpu_MemWr_i) begin
              data_r[idx_s]  <= bus.cpu_wdata_i;
              dirty_r[idx_s] <= 1'b1;
            end
          end else if (req_s) begin
            state_r <= victim_dirty_s ? WB : FILL;
          end
        end
        WB: begin
          if (last_s) begin
            state_r <= FILL;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FILL: begin
          if (last_s) begin
            // Memory data is combinational, so the last strobe cycle carries the refill word.
            data_r[idx_s]  <= bus.mem_rdata_i;
            tag_r[idx_s]   <= tag_s;
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
            state_r        <= IDLE;
            cnt_r          <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic fill_done_r;

  // Hit/miss statistics; the re-check hit right after a refill is part of the miss, not a new hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o   <= 32'd0;
      miss_cnt_o  <= 32'd0;
      fill_done_r <= 1'b0;
    end else begin
      fill_done_r <= (state_r == FILL) && last_s;
      if ((state_r == IDLE) && req_s && !hit_s) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end else if ((state_r == IDLE) && req_s && hit_s && !fill_done_r) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        hit_cnt_o <= hit_cnt_o;
      end
    end
  end
`endif

endmodule
